// File: rtl/w_grf_pkg.sv
// Shared W-stage definitions: sizes, opcode/funct encodings, write-data select and decoder output.
package w_grf_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    // R-type funct codes (instr[5:0]) that produce a register write
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [AW-1:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        WD_NONE   = 2'd0,
        WD_RESULT = 2'd1,
        WD_RD     = 2'd2,
        WD_PC8    = 2'd3
    } wd_sel_e;

    typedef struct packed {
        logic          wr_en;
        logic [AW-1:0] a3;
        wd_sel_e       wd_sel;
    } w_ctrl_t;

endpackage

// File: rtl/w_ctrl.sv
// W-stage decoder: instruction -> {write enable, destination, write-data source}.
//   instr : instruction in the W pipeline register
//   ctrl  : decoded write request (a3 may be 0; $0 suppression is done by the caller)
module w_ctrl
    import w_grf_pkg::*;
(
    input  logic [DW-1:0] instr,
    output w_ctrl_t       ctrl
);

    logic [5:0]    op;
    logic [5:0]    fn;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [9:0]    unused_fields;

    assign op            = instr[31:26];
    assign rt            = instr[20:16];
    assign rd            = instr[15:11];
    assign fn            = instr[5:0];
    assign unused_fields = {instr[25:21], instr[10:6]};

    // Anything not listed (stores, branches, j, jr, mult/div, mthi/mtlo, unknown) writes nothing.
    always_comb begin
        ctrl = '{wr_en: 1'b0, a3: '0, wd_sel: WD_NONE};
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU, FN_MFHI, FN_MFLO:
                        ctrl = '{wr_en: 1'b1, a3: rd, wd_sel: WD_RESULT};
                    FN_JALR:
                        ctrl = '{wr_en: 1'b1, a3: rd, wd_sel: WD_PC8};
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                ctrl = '{wr_en: 1'b1, a3: rt, wd_sel: WD_RESULT};
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
                ctrl = '{wr_en: 1'b1, a3: rt, wd_sel: WD_RD};
            OP_JAL:
                ctrl = '{wr_en: 1'b1, a3: REG_RA, wd_sel: WD_PC8};
            default: ;
        endcase
    end

endmodule

// File: rtl/w_grf.sv
// Write-back stage and 32x32 general register file with W->D bypass.
//   clk, reset           : clock, synchronous active-high reset (clears all registers)
//   W_Instr/W_PC8/W_RD/W_Result : W pipeline register contents
//   D_A1, D_A2 / D_RD1, D_RD2   : combinational D-stage read ports
//   W_WE, W_A3, W_WD, W_PC      : write actually performed this cycle (write-log view)
module w_grf
    import w_grf_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] W_Instr,
    input  logic [DW-1:0] W_PC8,
    input  logic [DW-1:0] W_RD,
    input  logic [DW-1:0] W_Result,
    input  logic [AW-1:0] D_A1,
    input  logic [AW-1:0] D_A2,
    output logic [DW-1:0] D_RD1,
    output logic [DW-1:0] D_RD2,
    output logic          W_WE,
    output logic [AW-1:0] W_A3,
    output logic [DW-1:0] W_WD,
    output logic [DW-1:0] W_PC
);

    w_ctrl_t       ctrl;
    logic [DW-1:0] sel_wd;
    logic [DW-1:0] rf [NREG];

    w_ctrl u_ctrl (
        .instr (W_Instr),
        .ctrl  (ctrl)
    );

    // Write-data source mux
    always_comb begin
        sel_wd = '0;
        case (ctrl.wd_sel)
            WD_RESULT: sel_wd = W_Result;
            WD_RD:     sel_wd = W_RD;
            WD_PC8:    sel_wd = W_PC8;
            default:   sel_wd = '0;
        endcase
    end

    // A write to $0 is dropped entirely: no store, no bypass, no log entry.
    assign W_WE = ctrl.wr_en && (ctrl.a3 != '0);
    assign W_A3 = W_WE ? ctrl.a3 : '0;
    assign W_WD = sel_wd;
    assign W_PC = W_PC8 - DW'(8);

    // Reads: $0 is hard zero, then same-cycle bypass from W, then storage.
    assign D_RD1 = (D_A1 == '0)                ? '0   :
                   (W_WE && (D_A1 == W_A3))     ? W_WD : rf[D_A1];
    assign D_RD2 = (D_A2 == '0)                ? '0   :
                   (W_WE && (D_A2 == W_A3))     ? W_WD : rf[D_A2];

    // Register array; reset wins over any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf[i] <= '0;
            end
        end else if (W_WE) begin
            rf[W_A3] <= W_WD;
        end
    end

endmodule

// File: tb/tb_w_grf.sv
// Bench for w_grf: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an architectural register-file model.
module tb_w_grf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] W_Instr = '0, W_PC8 = '0, W_RD = '0, W_Result = '0;
    logic [4:0]  D_A1 = '0, D_A2 = '0;
    logic [31:0] D_RD1, D_RD2, W_WD, W_PC;
    logic        W_WE;
    logic [4:0]  W_A3;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m [32];
    bit          m_init = 1'b0;

    logic [5:0] fn_tab [26] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                                6'h10, 6'h12, 6'h09, 6'h08, 6'h18, 6'h19, 6'h1a, 6'h1b,
                                6'h11, 6'h13};
    logic [5:0] ld_tab [5] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    logic [5:0] nw_tab [9] = '{6'h28, 6'h29, 6'h2b, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02};

    always #5 clk = ~clk;

    w_grf dut (
        .clk      (clk),
        .reset    (reset),
        .W_Instr  (W_Instr),
        .W_PC8    (W_PC8),
        .W_RD     (W_RD),
        .W_Result (W_Result),
        .D_A1     (D_A1),
        .D_A2     (D_A2),
        .D_RD1    (D_RD1),
        .D_RD2    (D_RD2),
        .W_WE     (W_WE),
        .W_A3     (W_A3),
        .W_WD     (W_WD),
        .W_PC     (W_PC)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Which register an instruction targets and with what value, from the ISA tables.
    function automatic void decode(input logic [31:0] ins, pc8, ld, res,
                                   output bit w, output logic [4:0] a, output logic [31:0] d);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        w = 1'b0; a = 5'd0; d = 32'd0;
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                           [6'h20:6'h27], 6'h2a, 6'h2b}) begin
                w = 1'b1; a = ins[15:11]; d = res;
            end else if (fn == 6'h09) begin
                w = 1'b1; a = ins[15:11]; d = pc8;
            end
        end else if (op inside {[6'h08:6'h0f]}) begin
            w = 1'b1; a = ins[20:16]; d = res;
        end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            w = 1'b1; a = ins[20:16]; d = ld;
        end else if (op == 6'h03) begin
            w = 1'b1; a = 5'd31; d = pc8;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] ra, input bit we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 5'd0)            return 32'd0;
        if (we && ra == wa)        return wd;
        return m[ra];
    endfunction

    // One cycle: drive after the edge, compare mid-cycle, commit the model for the next edge.
    task automatic step(input bit rst, input logic [31:0] ins, pc8, ld, res,
                        input logic [4:0] a1, a2);
        bit          w, we;
        logic [4:0]  a;
        logic [31:0] d;
        @(posedge clk);
        #1;
        reset = rst; W_Instr = ins; W_PC8 = pc8; W_RD = ld; W_Result = res;
        D_A1 = a1; D_A2 = a2;
        #3;
        decode(ins, pc8, ld, res, w, a, d);
        we = w && (a != 5'd0);
        chk("W_WE", 32'(W_WE), 32'(we));
        chk("W_A3", 32'(W_A3), we ? 32'(a) : 32'd0);
        chk("W_WD", W_WD, d);
        chk("W_PC", W_PC, pc8 - 32'd8);
        if (m_init) begin
            chk("D_RD1", D_RD1, model_read(a1, we, a, d));
            chk("D_RD2", D_RD2, model_read(a2, we, a, d));
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) m[i] = 32'd0;
            m_init = 1'b1;
        end else if (we) begin
            m[a] = d;
        end
    endtask

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] fn;
        case ($urandom_range(0, 9))
            0, 1, 2: begin
                fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 25)];
                return rtype(rand_reg(), rand_reg(), rand_reg(), fn);
            end
            3:       return itype(6'h08 + 6'($urandom_range(0, 7)), rand_reg(), rand_reg(), 16'($urandom));
            4:       return itype(ld_tab[$urandom_range(0, 4)], rand_reg(), rand_reg(), 16'($urandom));
            5:       return itype(nw_tab[$urandom_range(0, 8)], rand_reg(), rand_reg(), 16'($urandom));
            6:       return {6'h03, 26'($urandom)};
            7:       return $urandom;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        // Reset and sweep every register through both ports
        step(1'b1, 32'd0, 32'd8, 32'd0, 32'd0, 5'd0, 5'd0);
        step(1'b1, 32'd0, 32'd8, 32'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 32'd0, 32'd8, 32'd0, 32'd0, 5'(i), 5'(31 - i));
            chk("reset_rd1", D_RD1, 32'd0);
            chk("reset_rd2", D_RD2, 32'd0);
            chk("reset_we", 32'(W_WE), 32'd0);
        end

        // ori $5,$0,0x1234: bypass, then storage
        step(1'b0, itype(6'h0d, 5'd0, 5'd5, 16'h1234), 32'h3008, 32'd0, 32'h1234, 5'd5, 5'd0);
        chk("ori_bypass", D_RD1, 32'h0000_1234);
        chk("ori_a3", 32'(W_A3), 32'd5);
        step(1'b0, 32'd0, 32'h300c, 32'd0, 32'd0, 5'd5, 5'd0);
        chk("ori_stored", D_RD1, 32'h0000_1234);

        // jal and lw
        step(1'b0, {6'h03, 26'h0000c00}, 32'h3008, 32'd0, 32'h77, 5'd31, 5'd0);
        chk("jal_a3", 32'(W_A3), 32'd31);
        chk("jal_wd", W_WD, 32'h0000_3008);
        chk("jal_pc", W_PC, 32'h0000_3000);
        step(1'b0, itype(6'h23, 5'd0, 5'd7, 16'h0010), 32'h300c, 32'hFFFF_FF80, 32'h10, 5'd0, 5'd0);
        chk("lw_wd", W_WD, 32'hFFFF_FF80);
        step(1'b0, 32'd0, 32'h3010, 32'd0, 32'd0, 5'd7, 5'd31);
        chk("lw_stored", D_RD1, 32'hFFFF_FF80);
        chk("jal_stored", D_RD2, 32'h0000_3008);

        // Writes to $0 and non-writing instructions
        step(1'b0, rtype(5'd1, 5'd2, 5'd0, 6'h21), 32'h3014, 32'd0, 32'hDEAD, 5'd0, 5'd5);
        chk("zero_we", 32'(W_WE), 32'd0);
        chk("zero_rd1", D_RD1, 32'd0);
        step(1'b0, itype(6'h2b, 5'd0, 5'd5, 16'h0), 32'h3018, 32'd1, 32'd2, 5'd5, 5'd0);
        chk("sw_we", 32'(W_WE), 32'd0);
        step(1'b0, itype(6'h04, 5'd5, 5'd5, 16'h4), 32'h301c, 32'd1, 32'd2, 5'd5, 5'd0);
        chk("beq_we", 32'(W_WE), 32'd0);
        step(1'b0, rtype(5'd5, 5'd7, 5'd5, 6'h18), 32'h3020, 32'd1, 32'd2, 5'd5, 5'd0);
        chk("mult_we", 32'(W_WE), 32'd0);
        step(1'b0, 32'd0, 32'h3024, 32'd0, 32'd0, 5'd5, 5'd0);
        chk("r5_kept", D_RD1, 32'h0000_1234);

        // Dual-port bypass, then reset discarding a pending write
        step(1'b0, itype(6'h0d, 5'd0, 5'd9, 16'hAAAA), 32'h3028, 32'd0, 32'hAAAA, 5'd9, 5'd9);
        chk("dual_rd1", D_RD1, 32'h0000_AAAA);
        chk("dual_rd2", D_RD2, 32'h0000_AAAA);
        step(1'b1, itype(6'h09, 5'd0, 5'd9, 16'h5555), 32'h302c, 32'd0, 32'h5555, 5'd9, 5'd5);
        chk("rst_bypass", D_RD1, 32'h0000_5555);
        chk("rst_prior", D_RD2, 32'h0000_1234);
        step(1'b0, 32'd0, 32'h3030, 32'd0, 32'd0, 5'd9, 5'd5);
        chk("rst_r9", D_RD1, 32'd0);
        chk("rst_r5", D_RD2, 32'd0);

        // jalr $3 and jr $31
        step(1'b0, rtype(5'd31, 5'd0, 5'd3, 6'h09), 32'h3010, 32'd0, 32'h99, 5'd0, 5'd0);
        chk("jalr_wd", W_WD, 32'h0000_3010);
        step(1'b0, rtype(5'd31, 5'd0, 5'd0, 6'h08), 32'h3040, 32'd0, 32'h99, 5'd3, 5'd0);
        chk("jr_we", 32'(W_WE), 32'd0);
        chk("jalr_stored", D_RD1, 32'h0000_3010);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 49) == 0, rand_instr(), $urandom, $urandom, $urandom,
                 ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
